// File: rtl/player_ctrl_multi.sv
// Player controller: one move plus optional bomb drop per player per tick, served in index order.
// A tick takes 2 cycles per player; each accepted drop adds a PLACE cycle plus one per place_ready stall.
module player_ctrl_multi #(
   parameter int ROWS      = 10,
   parameter int COLS      = 10,
   parameter int NPLAYERS  = 2,
   parameter int MOVE_GAP  = 1,
   parameter int MAX_BOMBS = 1,
   localparam int RW = $clog2(ROWS),
   localparam int CW = $clog2(COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   input  logic [2*NPLAYERS-1:0]  dir,
   input  logic [NPLAYERS-1:0]    dir_valid,
   input  logic [NPLAYERS-1:0]    drop,
   input  logic [NPLAYERS-1:0]    alive,
   input  logic [ROWS*COLS-1:0]   wall_map,
   input  logic [ROWS*COLS-1:0]   bomb_map,
   input  logic [NPLAYERS-1:0]    bomb_done,
   output logic                   place_valid,
   input  logic                   place_ready,
   output logic [RW-1:0]          place_row,
   output logic [CW-1:0]          place_col,
   output logic [1:0]             place_owner,
   output logic [RW*NPLAYERS-1:0] pos_row,
   output logic [CW*NPLAYERS-1:0] pos_col,
   output logic [NPLAYERS-1:0]    moved,
   output logic                   busy,
   output logic                   tick_overrun
);
   localparam int MW = $clog2(ROWS*COLS);

   typedef enum logic [1:0] {IDLE, EVAL, PLACE, NEXT} state_t;

   state_t              state, state_nxt;
   logic [1:0]          idx;
   logic [RW-1:0]       row_q [NPLAYERS];
   logic [CW-1:0]       col_q [NPLAYERS];
   logic [3:0]          cd    [NPLAYERS];
   logic [2:0]          outst [NPLAYERS];
   logic [NPLAYERS-1:0] cd_ok;
   logic [NPLAYERS-1:0] moved_q;
   logic                place_valid_q;
   logic [RW-1:0]       place_row_q;
   logic [CW-1:0]       place_col_q;
   logic [1:0]          place_owner_q;
   logic                overrun_q;

   logic [RW-1:0] cur_row, tgt_row;
   logic [CW-1:0] cur_col, tgt_col;
   logic [1:0]    cur_dir;
   logic          cur_alive, cur_dv, cur_drop, cur_cd_ok;
   logic [2:0]    cur_outst;
   logic [MW-1:0] cur_cell, tgt_cell;
   logic          in_range, occupied, move_ok, drop_ok;

   function automatic logic [RW-1:0] spawn_row(input int p);
      return (p == 1 || p == 3) ? RW'(ROWS-1) : '0;
   endfunction

   function automatic logic [CW-1:0] spawn_col(input int p);
      return (p == 1 || p == 2) ? CW'(COLS-1) : '0;
   endfunction

   // Decision logic for the player currently in EVAL.
   always_comb begin
      cur_row   = '0;
      cur_col   = '0;
      cur_dir   = '0;
      cur_alive = 1'b0;
      cur_dv    = 1'b0;
      cur_drop  = 1'b0;
      cur_cd_ok = 1'b0;
      cur_outst = '0;
      for (int p = 0; p < NPLAYERS; p++) begin
         if (idx == 2'(p)) begin
            cur_row   = row_q[p];
            cur_col   = col_q[p];
            cur_dir   = dir[2*p +: 2];
            cur_alive = alive[p];
            cur_dv    = dir_valid[p];
            cur_drop  = drop[p];
            cur_cd_ok = cd_ok[p];
            cur_outst = outst[p];
         end
      end

      // Target stays on the current cell when out of range so map lookups stay in bounds.
      tgt_row  = cur_row;
      tgt_col  = cur_col;
      in_range = 1'b0;
      case (cur_dir)
         2'b00: if (cur_row != '0) begin
            in_range = 1'b1;
            tgt_row  = cur_row - 1'b1;
         end
         2'b01: if (cur_row != RW'(ROWS-1)) begin
            in_range = 1'b1;
            tgt_row  = cur_row + 1'b1;
         end
         2'b10: if (cur_col != '0) begin
            in_range = 1'b1;
            tgt_col  = cur_col - 1'b1;
         end
         default: if (cur_col != CW'(COLS-1)) begin
            in_range = 1'b1;
            tgt_col  = cur_col + 1'b1;
         end
      endcase

      cur_cell = MW'(int'(cur_row) * COLS + int'(cur_col));
      tgt_cell = MW'(int'(tgt_row) * COLS + int'(tgt_col));

      occupied = 1'b0;
      for (int p = 0; p < NPLAYERS; p++) begin
         if (idx != 2'(p) && alive[p] && row_q[p] == tgt_row && col_q[p] == tgt_col)
            occupied = 1'b1;
      end

      move_ok = cur_alive && cur_dv && cur_cd_ok && in_range &&
                !wall_map[tgt_cell] && !bomb_map[tgt_cell] && !occupied;
      drop_ok = cur_alive && cur_drop && (cur_outst < 3'(MAX_BOMBS)) && !bomb_map[cur_cell];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick) state_nxt = EVAL;
         EVAL:    state_nxt = drop_ok ? PLACE : NEXT;
         PLACE:   if (place_ready) state_nxt = NEXT;
         NEXT:    state_nxt = (idx == 2'(NPLAYERS-1)) ? IDLE : EVAL;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != IDLE);
      place_valid  = place_valid_q;
      place_row    = place_row_q;
      place_col    = place_col_q;
      place_owner  = place_owner_q;
      moved        = moved_q;
      tick_overrun = overrun_q;
      pos_row      = '0;
      pos_col      = '0;
      for (int p = 0; p < NPLAYERS; p++) begin
         pos_row[p*RW +: RW] = row_q[p];
         pos_col[p*CW +: CW] = col_q[p];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx           <= '0;
         cd_ok         <= '0;
         moved_q       <= '0;
         place_valid_q <= 1'b0;
         place_row_q   <= '0;
         place_col_q   <= '0;
         place_owner_q <= '0;
         overrun_q     <= 1'b0;
         for (int p = 0; p < NPLAYERS; p++) begin
            row_q[p] <= spawn_row(p);
            col_q[p] <= spawn_col(p);
            cd[p]    <= '0;
            outst[p] <= '0;
         end
      end else begin
         moved_q   <= '0;
         overrun_q <= tick && (state != IDLE);
         case (state)
            IDLE: if (tick) begin
               idx <= '0;
               // Eligibility is taken from the pre-decrement count, so MOVE_GAP ticks separate moves.
               for (int p = 0; p < NPLAYERS; p++) begin
                  cd_ok[p] <= (cd[p] == '0);
                  if (cd[p] != '0) cd[p] <= cd[p] - 1'b1;
               end
            end
            EVAL: begin
               for (int p = 0; p < NPLAYERS; p++) begin
                  if (idx == 2'(p) && move_ok) begin
                     row_q[p]   <= tgt_row;
                     col_q[p]   <= tgt_col;
                     cd[p]      <= 4'(MOVE_GAP-1);
                     moved_q[p] <= 1'b1;
                  end
               end
               if (drop_ok) begin
                  place_valid_q <= 1'b1;
                  place_row_q   <= cur_row;
                  place_col_q   <= cur_col;
                  place_owner_q <= idx;
               end
            end
            PLACE:   if (place_ready) place_valid_q <= 1'b0;
            NEXT:    idx <= idx + 1'b1;
            default: ;
         endcase

         for (int p = 0; p < NPLAYERS; p++) begin
            if (state == PLACE && place_ready && idx == 2'(p)) begin
               if (!bomb_done[p]) outst[p] <= outst[p] + 1'b1;
            end else if (bomb_done[p] && outst[p] != '0) begin
               outst[p] <= outst[p] - 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_player_ctrl_multi.sv
module tb_player_ctrl_multi;
   localparam int ROWS = 10;
   localparam int COLS = 10;
   localparam int NP   = 2;
   localparam int GAP  = 3;
   localparam int MAXB = 1;
   localparam int RW   = 4;
   localparam int CW   = 4;

   logic                 clk = 1'b0;
   logic                 rst, tick, place_ready;
   logic [2*NP-1:0]      dir;
   logic [NP-1:0]        dir_valid, drop, alive, bomb_done;
   logic [ROWS*COLS-1:0] wall_map, bomb_map;
   logic                 place_valid, busy, tick_overrun;
   logic [RW-1:0]        place_row;
   logic [CW-1:0]        place_col;
   logic [1:0]           place_owner;
   logic [RW*NP-1:0]     pos_row;
   logic [CW*NP-1:0]     pos_col;
   logic [NP-1:0]        moved;

   player_ctrl_multi #(.ROWS(ROWS), .COLS(COLS), .NPLAYERS(NP), .MOVE_GAP(GAP), .MAX_BOMBS(MAXB)) dut (
      .clk(clk), .rst(rst), .tick(tick), .dir(dir), .dir_valid(dir_valid), .drop(drop),
      .alive(alive), .wall_map(wall_map), .bomb_map(bomb_map), .bomb_done(bomb_done),
      .place_valid(place_valid), .place_ready(place_ready), .place_row(place_row),
      .place_col(place_col), .place_owner(place_owner), .pos_row(pos_row), .pos_col(pos_col),
      .moved(moved), .busy(busy), .tick_overrun(tick_overrun)
   );

   always #5 clk = ~clk;

   // Reference model: positions, tick number of each player's last move, outstanding bombs.
   int m_row[NP], m_col[NP], m_last[NP], m_out[NP];
   int m_tk;
   int tests = 0;
   int fails = 0;
   int last_n, last_nplace, last_pr, last_pc, last_po;
   bit last_mv0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_row[0] = 0;        m_col[0] = 0;
      m_row[1] = ROWS - 1; m_col[1] = COLS - 1;
      for (int p = 0; p < NP; p++) begin
         m_last[p] = -100;
         m_out[p]  = 0;
      end
      m_tk = 0;
   endtask

   task automatic bomb_done_pulse(input logic [NP-1:0] mask);
      bomb_done = mask;
      for (int p = 0; p < NP; p++)
         if (mask[p] && m_out[p] > 0) m_out[p]--;
      @(negedge clk);
      bomb_done = '0;
   endtask

   task automatic do_tick(input int stall, input bit ovr);
      int er[$], ec[$], eo[$], gr[$], gc[$], go[$];
      bit emv[NP];
      int mv_cnt[NP];
      int n, waits, stalls, ovr_cnt, mv0_at;
      m_tk++;
      for (int p = 0; p < NP; p++) begin
         int r, c, tr, tc;
         bit ok;
         emv[p] = 0;
         mv_cnt[p] = 0;
         r = m_row[p]; c = m_col[p]; tr = r; tc = c;
         if (alive[p]) begin
            case (dir[2*p +: 2])
               2'd0: tr = r - 1;
               2'd1: tr = r + 1;
               2'd2: tc = c - 1;
               default: tc = c + 1;
            endcase
            ok = dir_valid[p] && (m_tk - m_last[p] >= GAP) &&
                 tr >= 0 && tr < ROWS && tc >= 0 && tc < COLS;
            if (ok) ok = !wall_map[tr*COLS + tc] && !bomb_map[tr*COLS + tc];
            for (int q = 0; q < NP; q++)
               if (q != p && alive[q] && m_row[q] == tr && m_col[q] == tc) ok = 0;
            if (drop[p] && m_out[p] < MAXB && !bomb_map[r*COLS + c]) begin
               er.push_back(r); ec.push_back(c); eo.push_back(p);
               m_out[p]++;
            end
            if (ok) begin
               m_row[p] = tr; m_col[p] = tc; m_last[p] = m_tk; emv[p] = 1;
            end
         end
      end

      n = 0; waits = 0; stalls = stall; ovr_cnt = 0; mv0_at = 0;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         tick = (ovr && n == 2);
         if (tick_overrun === 1'b1) ovr_cnt++;
         for (int p = 0; p < NP; p++)
            if (moved[p] === 1'b1) begin
               mv_cnt[p]++;
               if (p == 0) mv0_at = n;
            end
         place_ready = 1'b0;
         if (place_valid === 1'b1) begin
            if (stalls > 0) begin
               stalls--; waits++;
            end else begin
               place_ready = 1'b1;
               gr.push_back(int'(place_row)); gc.push_back(int'(place_col)); go.push_back(int'(place_owner));
            end
         end
         @(negedge clk);
      end
      tick = 1'b0;
      place_ready = 1'b0;

      chk("busy_len", n, 2*NP + er.size() + waits);
      chk("overrun_pulses", ovr_cnt, ovr ? 1 : 0);
      chk("place_count", gr.size(), er.size());
      for (int i = 0; i < er.size() && i < gr.size(); i++) begin
         chk("place_row", gr[i], er[i]);
         chk("place_col", gc[i], ec[i]);
         chk("place_owner", go[i], eo[i]);
      end
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("moved%0d", p), mv_cnt[p], emv[p]);
         chk($sformatf("pos_row%0d", p), pos_row[p*RW +: RW], m_row[p]);
         chk($sformatf("pos_col%0d", p), pos_col[p*CW +: CW], m_col[p]);
      end
      if (emv[0]) chk("moved0_cycle", mv0_at, 2);
      chk("place_valid_idle", place_valid, 0);

      last_n = n;
      last_nplace = gr.size();
      last_mv0 = (mv_cnt[0] != 0);
      if (gr.size() > 0) begin
         last_pr = gr[0]; last_pc = gc[0]; last_po = go[0];
      end
   endtask

   task automatic idle_ticks(input int k);
      dir_valid = '0;
      drop = '0;
      repeat (k) do_tick(0, 0);
   endtask

   task automatic steer(input int r0, input int c0, input int r1, input int c1);
      int gr[NP], gc[NP];
      gr[0] = r0; gc[0] = c0; gr[1] = r1; gc[1] = c1;
      drop = '0;
      for (int it = 0; it < 60; it++) begin
         logic [NP-1:0]   dv;
         logic [2*NP-1:0] d;
         dv = '0; d = '0;
         for (int p = 0; p < NP; p++) begin
            if (m_row[p] < gr[p])      begin d[2*p +: 2] = 2'd1; dv[p] = 1'b1; end
            else if (m_row[p] > gr[p]) begin d[2*p +: 2] = 2'd0; dv[p] = 1'b1; end
            else if (m_col[p] < gc[p]) begin d[2*p +: 2] = 2'd3; dv[p] = 1'b1; end
            else if (m_col[p] > gc[p]) begin d[2*p +: 2] = 2'd2; dv[p] = 1'b1; end
         end
         if (dv == '0) break;
         dir = d;
         dir_valid = dv;
         do_tick(0, 0);
      end
      dir_valid = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] gap_mask;
      int n;
      rst = 1'b1; tick = 1'b0; place_ready = 1'b0; dir = '0; dir_valid = '0; drop = '0;
      alive = '1; bomb_done = '0; wall_map = '0; bomb_map = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_p0_row", pos_row[3:0], 0);
      chk("rst_p0_col", pos_col[3:0], 0);
      chk("rst_p1_row", pos_row[7:4], 9);
      chk("rst_p1_col", pos_col[7:4], 9);
      chk("rst_busy", busy, 0);
      chk("rst_place_valid", place_valid, 0);
      chk("rst_moved", moved, 0);
      chk("rst_overrun", tick_overrun, 0);
      rst = 1'b0;
      @(negedge clk);

      // Edge of the arena, then a wall, then a clear path.
      dir = 4'b0000; dir_valid = 2'b01;
      do_tick(0, 0);
      chk("up_at_edge_moved", last_mv0, 0);
      dir = 4'b0011; wall_map[1] = 1'b1;
      do_tick(0, 0);
      chk("wall_moved", last_mv0, 0);
      wall_map = '0;
      do_tick(0, 0);
      chk("clear_moved", last_mv0, 1);
      chk("clear_p0_col", pos_col[3:0], 1);

      // Head-on contention: the lower index wins the shared cell.
      steer(4, 4, 4, 6);
      chk("steer_p0_col", pos_col[3:0], 4);
      chk("steer_p1_col", pos_col[7:4], 6);
      idle_ticks(3);
      dir = 4'b1011; dir_valid = 2'b11;
      do_tick(0, 0);
      chk("contend_p0_col", pos_col[3:0], 5);
      chk("contend_p1_col", pos_col[7:4], 6);

      // Cooldown with the request held high.
      idle_ticks(3);
      dir = 4'b0001; dir_valid = 2'b01;
      gap_mask = '0;
      for (int i = 0; i < 7; i++) begin
         do_tick(0, 0);
         gap_mask[i] = last_mv0;
      end
      chk("gap_pattern", gap_mask, 7'b1001001);

      // Drop while moving, with a stalled bomb table.
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      model_reset();
      steer(2, 2, 9, 9);
      idle_ticks(3);
      dir = 4'b0011; dir_valid = 2'b01; drop = 2'b01;
      do_tick(2, 0);
      chk("drop_busy_len", last_n, 7);
      chk("drop_nplace", last_nplace, 1);
      chk("drop_row", last_pr, 2);
      chk("drop_col", last_pc, 2);
      chk("drop_owner", last_po, 0);
      chk("drop_p0_col", pos_col[3:0], 3);
      dir_valid = 2'b00;
      do_tick(0, 0);
      chk("drop_refused", last_nplace, 0);
      bomb_done_pulse(2'b01);
      do_tick(0, 0);
      chk("drop_after_done", last_nplace, 1);
      chk("drop2_col", last_pc, 3);

      // Tick while busy.
      drop = '0;
      do_tick(0, 1);

      // Reset while a placement is pending.
      bomb_done_pulse(2'b11);
      drop = 2'b01; dir_valid = '0; place_ready = 1'b0;
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      n = 0;
      while (place_valid !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("pv_before_rst", place_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("pv_after_rst", place_valid, 0);
      chk("busy_after_rst", busy, 0);
      chk("p0_row_after_rst", pos_row[3:0], 0);
      chk("p0_col_after_rst", pos_col[3:0], 0);
      chk("p1_row_after_rst", pos_row[7:4], 9);
      chk("p1_col_after_rst", pos_col[7:4], 9);
      rst = 1'b0; drop = '0;
      model_reset();
      @(negedge clk);

      // Randomized ticks against the model.
      for (int t = 0; t < 150; t++) begin
         for (int i = 0; i < ROWS*COLS; i++) begin
            wall_map[i] = ($urandom_range(0, 9) == 0);
            bomb_map[i] = ($urandom_range(0, 11) == 0);
         end
         dir = 4'($urandom);
         dir_valid = 2'($urandom);
         drop = 2'($urandom) & 2'($urandom);
         for (int p = 0; p < NP; p++) alive[p] = ($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 3) == 0) bomb_done_pulse(2'($urandom));
         do_tick($urandom_range(0, 3), $urandom_range(0, 7) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
